// File: rtl/forward_ctrl.sv
// Two-slot (MEM/WB) operand forwarding and load-use detection for an EX stage.
// Zero-latency fwd/stall outputs; no backpressure of its own, the controller holds via advance or bubbles via flush.
module forward_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        flush,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rd_ex,
    input  logic        regwrite_ex,
    input  logic        memread_ex,
    input  logic [31:0] alu_ex,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] mem_data,
    output logic [31:0] wb_data,
    output logic        stall_req
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic [31:0] val;
    } mem_slot_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] val;
    } wb_slot_t;

    mem_slot_t mem_q;
    wb_slot_t  wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (advance) begin
            // A load's result arrives on mem_rdata in the cycle it sits in MEM.
            wb_q.rd  <= mem_q.rd;
            wb_q.rw  <= mem_q.rw;
            wb_q.val <= mem_q.ld ? mem_rdata : mem_q.val;
            if (flush) begin
                mem_q <= '0;
            end else begin
                mem_q.rd  <= rd_ex;
                mem_q.rw  <= regwrite_ex;
                mem_q.ld  <= memread_ex;
                mem_q.val <= alu_ex;
            end
        end
    end

    logic hit_m_a, hit_m_b, hit_w_a, hit_w_b;
    logic use_a, use_b;

    always_comb begin
        hit_m_a = mem_q.rw && (mem_q.rd != 5'd0) && (mem_q.rd == rs_ex);
        hit_m_b = mem_q.rw && (mem_q.rd != 5'd0) && (mem_q.rd == rt_ex);
        hit_w_a = wb_q.rw  && (wb_q.rd  != 5'd0) && (wb_q.rd  == rs_ex);
        hit_w_b = wb_q.rw  && (wb_q.rd  != 5'd0) && (wb_q.rd  == rt_ex);
        use_a   = hit_m_a && mem_q.ld;
        use_b   = hit_m_b && mem_q.ld;
    end

    // A pending load in MEM masks the older WB copy: the operand must wait.
    always_comb begin
        fwd_a = FWD_RF;
        if (hit_m_a) begin
            fwd_a = use_a ? FWD_RF : FWD_MEM;
        end else if (hit_w_a) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_RF;
        if (hit_m_b) begin
            fwd_b = use_b ? FWD_RF : FWD_MEM;
        end else if (hit_w_b) begin
            fwd_b = FWD_WB;
        end
    end

    assign stall_req = use_a || use_b;
    assign mem_data  = mem_q.val;
    assign wb_data   = wb_q.val;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: expected values queued per step, drained after each step.
module tb_forward_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic        flush;
    logic [4:0]  rs_ex;
    logic [4:0]  rt_ex;
    logic [4:0]  rd_ex;
    logic        regwrite_ex;
    logic        memread_ex;
    logic [31:0] alu_ex;
    logic [31:0] mem_rdata;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] mem_data;
    logic [31:0] wb_data;
    logic        stall_req;

    always #5 clk = ~clk;

    forward_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .flush       (flush),
        .rs_ex       (rs_ex),
        .rt_ex       (rt_ex),
        .rd_ex       (rd_ex),
        .regwrite_ex (regwrite_ex),
        .memread_ex  (memread_ex),
        .alu_ex      (alu_ex),
        .mem_rdata   (mem_rdata),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .mem_data    (mem_data),
        .wb_data     (wb_data),
        .stall_req   (stall_req)
    );

    typedef enum int {S_FA, S_FB, S_MD, S_WD, S_ST} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            S_FA:    return {30'd0, fwd_a};
            S_FB:    return {30'd0, fwd_b};
            S_MD:    return mem_data;
            S_WD:    return wb_data;
            default: return {31'd0, stall_req};
        endcase
    endfunction

    task automatic want(input string tag, input sel_t s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sel);
            n_vec++;
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [4:0] rd, input logic rw, input logic ld, input logic [31:0] alu);
        rd_ex       = rd;
        regwrite_ex = rw;
        memread_ex  = ld;
        alu_ex      = alu;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; advance = 1'b0; flush = 1'b0; mem_rdata = 32'd0;
        rs_ex = 5'd3; rt_ex = 5'd3;
        ex(5'd3, 1'b1, 1'b0, 32'h55);
        tick();
        tick();
        want("rst_fa", S_FA, 0); want("rst_fb", S_FB, 0);
        want("rst_md", S_MD, 0); want("rst_wd", S_WD, 0); want("rst_st", S_ST, 0);
        drain();

        // MEM forward
        reset = 1'b0; advance = 1'b1;
        ex(5'd5, 1'b1, 1'b0, 32'd32767);
        tick();
        rs_ex = 5'd5; rt_ex = 5'd0;
        want("mem_fa", S_FA, 1); want("mem_md", S_MD, 32767); want("mem_fb", S_FB, 0);
        drain();

        // MEM beats WB on the same register, then WB forward
        ex(5'd5, 1'b1, 1'b0, 32'd16383);
        tick();
        ex(5'd5, 1'b1, 1'b0, 32'd65535);
        tick();
        rs_ex = 5'd5;
        want("prio_fa", S_FA, 1); want("prio_md", S_MD, 65535); want("prio_wd", S_WD, 16383);
        drain();
        ex(5'd6, 1'b1, 1'b0, 32'd100);
        tick();
        rt_ex = 5'd5; rs_ex = 5'd6;
        want("wb_fb", S_FB, 2); want("wb_wd", S_WD, 65535); want("wb_fa_mem", S_FA, 1);
        drain();

        // register 0 never forwards
        ex(5'd0, 1'b1, 1'b0, 32'd77);
        tick();
        rs_ex = 5'd0; rt_ex = 5'd6;
        want("r0_fa", S_FA, 0); want("r0_fb_wb", S_FB, 2); want("r0_md", S_MD, 77);
        drain();

        // load-use stall then flush
        ex(5'd7, 1'b1, 1'b1, 32'h40);
        tick();
        rt_ex = 5'd7; rs_ex = 5'd0;
        want("lu_st", S_ST, 1); want("lu_fb", S_FB, 0); want("lu_fa", S_FA, 0);
        drain();
        flush = 1'b1; mem_rdata = 32'd1234;
        tick();
        flush = 1'b0;
        want("lu2_st", S_ST, 0); want("lu2_fb", S_FB, 2);
        want("lu2_wd", S_WD, 1234); want("lu2_md", S_MD, 0);
        drain();

        // pending load masks an older WB match on both operands
        ex(5'd8, 1'b1, 1'b0, 32'd5);
        tick();
        ex(5'd8, 1'b1, 1'b1, 32'd9);
        tick();
        rs_ex = 5'd8; rt_ex = 5'd8;
        want("mask_st", S_ST, 1); want("mask_fa", S_FA, 0); want("mask_fb", S_FB, 0);
        want("mask_wd", S_WD, 5);
        drain();

        // load data captured into WB
        ex(5'd9, 1'b1, 1'b0, 32'hABCD);
        mem_rdata = 32'h1111;
        tick();
        rs_ex = 5'd9; rt_ex = 5'd8;
        want("ld_wd", S_WD, 32'h1111); want("ld_fa", S_FA, 1); want("ld_fb", S_FB, 2);
        drain();

        // hold for three edges, flush ignored while held
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush = i[0];
            ex(5'd10, 1'b1, 1'b1, 32'hDEAD0000 + i);
            mem_rdata = 32'h2222;
            tick();
            want("hold_fa", S_FA, 1); want("hold_fb", S_FB, 2);
            want("hold_md", S_MD, 32'hABCD); want("hold_wd", S_WD, 32'h1111);
            want("hold_st", S_ST, 0);
            drain();
        end

        // flush edge: bubble in MEM, WB takes the old MEM entry
        advance = 1'b1; flush = 1'b1;
        ex(5'd11, 1'b1, 1'b0, 32'h777);
        tick();
        flush = 1'b0;
        rs_ex = 5'd11; rt_ex = 5'd9;
        want("fl_fa", S_FA, 0); want("fl_md", S_MD, 0);
        want("fl_fb", S_FB, 2); want("fl_wd", S_WD, 32'hABCD);
        drain();

        // reset mid-operation discards both slots, then first edge loads normally
        ex(5'd12, 1'b1, 1'b0, 32'd3);
        tick();
        reset = 1'b1;
        ex(5'd13, 1'b1, 1'b0, 32'd4);
        tick();
        rs_ex = 5'd12; rt_ex = 5'd13;
        want("mrst_fa", S_FA, 0); want("mrst_fb", S_FB, 0);
        want("mrst_md", S_MD, 0); want("mrst_wd", S_WD, 0); want("mrst_st", S_ST, 0);
        drain();
        reset = 1'b0;
        ex(5'd13, 1'b1, 1'b0, 32'd42);
        tick();
        want("post_fb", S_FB, 1); want("post_md", S_MD, 42); want("post_fa", S_FA, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
